console_tx: RTL
===============

CONSOLE_TX -- requirements
Module: console_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (minimum 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte buffer entries (power of two, minimum 2).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port console_we  input  1  core console write strobe, one byte per asserted cycle.
REQ-006 SHALL have port console_wdata  input  XLEN  core console write data; only bits [7:0] are used.
REQ-007 SHALL have port tx  output  1  serial line, idles high.
REQ-008 SHALL have port busy  output  1  high while the FIFO is non-empty or a frame is in flight.
REQ-009 SHALL have port full  output  1  high when the FIFO holds FIFO_DEPTH bytes.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-011 SHALL enqueue console_wdata[7:0] on a rising edge with console_we=1 when the FIFO is not full or a pop occurs on that same edge.
REQ-012 SHALL drop a write arriving while full with no same-edge pop, leaving FIFO contents unchanged, and assert overflow on the following cycle only.
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY (Configuration only) and STOP.
REQ-014 SHALL pop the head byte and move IDLE->START on the first edge at which the FIFO is non-empty, driving tx low from that edge.
REQ-015 SHALL give a 1-cycle latency: a byte written at edge E into an empty FIFO with an IDLE FSM drives tx low after edge E+1.
REQ-016 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles, timed by a bit counter that resets at every bit boundary.
REQ-017 SHALL send 8 data bits LSB first in DATA, tracked by a 3-bit index that wraps 7->0 on leaving DATA.
REQ-018 SHALL drive tx high for one bit time in STOP, then pop and go to START if the FIFO is non-empty, otherwise go to IDLE.
REQ-019 SHALL register tx with no combinational path from any input.
REQ-020 SHALL send bytes in write order, with no loss except under REQ-012.

Reset
REQ-021 SHALL, on reset assertion at any time (including mid-frame), immediately set tx=1, busy=0, full=0, overflow=0, state=IDLE, empty the FIFO and clear all counters.
REQ-022 SHALL ignore console_we while reset is high; the first accepted write is on the first edge with reset low.

Configuration
REQ-023 SHALL, with macro CONSOLE_TX_PARITY_EN defined, insert a PARITY state between DATA and STOP that sends the even-parity bit (XOR of the 8 data bits) for one bit time, making an 11-bit frame.
REQ-024 SHALL, with CONSOLE_TX_PARITY_EN undefined, go DATA->STOP directly and send a 10-bit frame, with no parity logic synthesized.

Structure
REQ-025 SHALL take XLEN from constants.vh and add there the state encodings (CONSOLE_TX_STATE_LEN plus IDLE/START/DATA/PARITY/STOP constants) for logger reuse.
REQ-026 SHALL implement the buffer as sub-module console_fifo (synchronous write/read, full/empty flags, simultaneous push+pop allowed, pointer wrap at FIFO_DEPTH).

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-027 SHALL check that writing 0x41 once after reset makes tx low for 4 cycles starting the cycle after the write edge, then send 1,0,0,0,0,0,1,0 (4 cycles each), then high for 4 cycles, with busy falling after the stop bit.
REQ-028 SHALL check that 6 consecutive writes 0x30..0x35 with the FSM busy on 0x30 accept 0x30..0x34 (full after 0x34), drop 0x35 with one overflow pulse, and emit 0x30..0x34 back-to-back with no idle gap between frames.
REQ-029 SHALL check that a write on the same edge that the FIFO is full and STOP pops is accepted with no overflow pulse.
REQ-030 SHALL check that reset asserted mid-DATA of 0x55 drives tx high immediately with busy=0, and that a later write of 0x0F transmits a clean frame.
REQ-031 SHALL check with CONSOLE_TX_PARITY_EN that 0x07 gives parity bit 1 and 0x03 gives parity bit 0, each frame lasting 44 cycles.
REQ-032 SHALL check that console_wdata=0xDEADBE41 with console_we=1 transmits only 0x41.

Source files
------------

// File: rtl/console_tx_pkg.sv
// Shared constants for the console transmitter: core data width and FSM state
// encodings, kept here so that loggers can decode the state.
package console_tx_pkg;

  localparam int XLEN = 32;

  localparam int CONSOLE_TX_STATE_LEN = 3;

  localparam logic [CONSOLE_TX_STATE_LEN-1:0] CONSOLE_TX_IDLE   = 3'd0;
  localparam logic [CONSOLE_TX_STATE_LEN-1:0] CONSOLE_TX_START  = 3'd1;
  localparam logic [CONSOLE_TX_STATE_LEN-1:0] CONSOLE_TX_DATA   = 3'd2;
  localparam logic [CONSOLE_TX_STATE_LEN-1:0] CONSOLE_TX_PARITY = 3'd3;
  localparam logic [CONSOLE_TX_STATE_LEN-1:0] CONSOLE_TX_STOP   = 3'd4;

endpackage

// File: rtl/console_fifo.sv
// Byte FIFO for the console transmitter: synchronous push/pop with full/empty
// flags; a push into a full FIFO is accepted only when a pop happens on the same edge.
module console_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/console_tx.sv
// Buffered 8N1 console transmitter. Define CONSOLE_TX_PARITY_EN to add an
// even-parity bit (8E1, 11-bit frame).
//
// state  | meaning
// IDLE   | line high, waiting for a buffered byte
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (CONSOLE_TX_PARITY_EN only)
// STOP   | stop bit (high); pops the next byte if one is waiting
module console_tx
  import console_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            console_we,
  input  logic [XLEN-1:0] console_wdata,
  output logic            tx,
  output logic            busy,
  output logic            full,
  output logic            overflow
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CONSOLE_TX_STATE_LEN-1:0] state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    frame_byte;
  logic [7:0]    head;
  logic          empty;
  logic          pop;
  logic          bit_done;
  logic          unused_wdata;

  assign unused_wdata = ^console_wdata[XLEN-1:8];

  assign bit_done = (bit_cnt == '0);
  assign pop      = !empty && ((state == CONSOLE_TX_IDLE) ||
                               ((state == CONSOLE_TX_STOP) && bit_done));
  assign busy     = (state != CONSOLE_TX_IDLE) || !empty;

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (console_we),
    .pop   (pop),
    .wdata (console_wdata[7:0]),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else       overflow <= console_we && full && !pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CONSOLE_TX_IDLE;
      tx         <= 1'b1;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      frame_byte <= '0;
    end else begin
      // Bit timer restarts at every bit boundary; IDLE keeps it preloaded.
      if (state == CONSOLE_TX_IDLE || bit_done) bit_cnt <= BIT_LAST;
      else                                      bit_cnt <= bit_cnt - 1'b1;

      case (state)
        CONSOLE_TX_IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            state      <= CONSOLE_TX_START;
            tx         <= 1'b0;
            frame_byte <= head;
          end
        end
        CONSOLE_TX_START: begin
          if (bit_done) begin
            state   <= CONSOLE_TX_DATA;
            tx      <= frame_byte[0];
            bit_idx <= '0;
          end
        end
        CONSOLE_TX_DATA: begin
          if (bit_done) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef CONSOLE_TX_PARITY_EN
              state <= CONSOLE_TX_PARITY;
              tx    <= ^frame_byte;
`else
              state <= CONSOLE_TX_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              tx <= frame_byte[bit_idx + 3'd1];
            end
          end
        end
`ifdef CONSOLE_TX_PARITY_EN
        CONSOLE_TX_PARITY: begin
          if (bit_done) begin
            state <= CONSOLE_TX_STOP;
            tx    <= 1'b1;
          end
        end
`endif
        CONSOLE_TX_STOP: begin
          if (bit_done) begin
            if (!empty) begin
              state      <= CONSOLE_TX_START;
              tx         <= 1'b0;
              frame_byte <= head;
            end else begin
              state <= CONSOLE_TX_IDLE;
              tx    <= 1'b1;
            end
          end
        end
        default: begin
          state <= CONSOLE_TX_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
